// File: rtl/acc_pkg.sv
// Shared definitions for the tile scheduler: FSM encoding and default widths.
package acc_pkg;

  localparam int unsigned TX_W_DEF = 8;
  localparam int unsigned TY_W_DEF = 8;
  localparam int unsigned OC_W_DEF = 6;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRun,
    StWbWait
  } sched_st_e;

endpackage

// File: rtl/acc_tile_idx_cnt.sv
// Three-level nested wrap counter walking X fastest, then Y, then OC.
module acc_tile_idx_cnt
  import acc_pkg::*;
#(
  parameter int unsigned TX_W = TX_W_DEF,
  parameter int unsigned TY_W = TY_W_DEF,
  parameter int unsigned OC_W = OC_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            advance,
  input  logic [TX_W-1:0] cnt_x,
  input  logic [TY_W-1:0] cnt_y,
  input  logic [OC_W-1:0] cnt_oc,
  output logic [TX_W-1:0] idx_x,
  output logic [TY_W-1:0] idx_y,
  output logic [OC_W-1:0] idx_oc,
  output logic            last
);

  logic [TX_W-1:0] x_d, x_q;
  logic [TY_W-1:0] y_d, y_q;
  logic [OC_W-1:0] oc_d, oc_q;
  logic            x_wrap, y_wrap, oc_wrap;

  // Counts are guaranteed nonzero while a job runs, so count-1 never underflows in use.
  assign x_wrap  = (x_q == cnt_x - TX_W'(1));
  assign y_wrap  = (y_q == cnt_y - TY_W'(1));
  assign oc_wrap = (oc_q == cnt_oc - OC_W'(1));
  assign last    = x_wrap & y_wrap & oc_wrap;

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    oc_d = oc_q;
    if (clear) begin
      x_d  = '0;
      y_d  = '0;
      oc_d = '0;
    end else if (advance) begin
      if (x_wrap) begin
        x_d = '0;
        if (y_wrap) begin
          y_d  = '0;
          oc_d = oc_q + OC_W'(1);
        end else begin
          y_d = y_q + TY_W'(1);
        end
      end else begin
        x_d = x_q + TX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q  <= '0;
      y_q  <= '0;
      oc_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      oc_q <= oc_d;
    end
  end

  assign idx_x  = x_q;
  assign idx_y  = y_q;
  assign idx_oc = oc_q;

endmodule

// File: rtl/acc_tile_sched.sv
// Tile scheduler: issues one engine start per tile over an X/Y/OC tile space,
// one tile in flight, and pulses done after the last tile retires.
module acc_tile_sched
  import acc_pkg::*;
#(
  parameter int unsigned TX_W = TX_W_DEF,
  parameter int unsigned TY_W = TY_W_DEF,
  parameter int unsigned OC_W = OC_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [TX_W-1:0] cfg_tiles_x,
  input  logic [TY_W-1:0] cfg_tiles_y,
  input  logic [OC_W-1:0] cfg_oc_grps,
  output logic            tile_start,
  output logic [TX_W-1:0] tile_x,
  output logic [TY_W-1:0] tile_y,
  output logic [OC_W-1:0] tile_oc,
  output logic            tile_last,
  input  logic            tile_done,
  input  logic            wbuf_wait,
  output logic            busy,
  output logic            done,
  output logic            err
);

  sched_st_e       state_d, state_q;
  logic [TX_W-1:0] tx_q;
  logic [TY_W-1:0] ty_q;
  logic [OC_W-1:0] oc_q;
  logic            err_d, err_q;
  logic            done_d, done_q;
  logic            cfg_ok, clear_idx, retire, advance, idx_last;

  assign cfg_ok = (|cfg_tiles_x) & (|cfg_tiles_y) & (|cfg_oc_grps);

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    done_d    = 1'b0;
    clear_idx = 1'b0;
    retire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tile_done) err_d = 1'b1;
        if (start) begin
          err_d = 1'b0;
          if (cfg_ok) begin
            clear_idx = 1'b1;
            state_d   = StIssue;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (tile_done) err_d = 1'b1;
        state_d = abort ? StIdle : StRun;
      end
      StRun: begin
        // abort wins over a coincident tile_done, which is then not an error
        if (abort) begin
          state_d = StIdle;
        end else if (tile_done) begin
          if (wbuf_wait) state_d = StWbWait;
          else           retire  = 1'b1;
        end
      end
      StWbWait: begin
        if (tile_done) err_d = 1'b1;
        if (abort)           state_d = StIdle;
        else if (!wbuf_wait) retire  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (retire) begin
      if (idx_last) begin
        done_d  = 1'b1;
        state_d = StIdle;
      end else begin
        state_d = StIssue;
      end
    end
  end

  assign advance = retire & ~idx_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= '0;
      ty_q    <= '0;
      oc_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      done_q  <= done_d;
      if (state_q == StIdle && start) begin
        tx_q <= cfg_tiles_x;
        ty_q <= cfg_tiles_y;
        oc_q <= cfg_oc_grps;
      end
    end
  end

  acc_tile_idx_cnt #(
    .TX_W(TX_W),
    .TY_W(TY_W),
    .OC_W(OC_W)
  ) u_idx_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_idx),
    .advance(advance),
    .cnt_x  (tx_q),
    .cnt_y  (ty_q),
    .cnt_oc (oc_q),
    .idx_x  (tile_x),
    .idx_y  (tile_y),
    .idx_oc (tile_oc),
    .last   (idx_last)
  );

  assign busy       = (state_q != StIdle);
  assign tile_start = (state_q == StIssue) & ~abort;
  assign tile_last  = idx_last & busy;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_acc_tile_sched.sv
// Directed bench for acc_tile_sched: tile order table plus hand-written corner sequences.
module tb_acc_tile_sched;
  import acc_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [7:0]      cfg_tiles_x = '0;
  logic [7:0]      cfg_tiles_y = '0;
  logic [5:0]      cfg_oc_grps = '0;
  logic            tile_start;
  logic [7:0]      tile_x;
  logic [7:0]      tile_y;
  logic [5:0]      tile_oc;
  logic            tile_last;
  logic            tile_done = 1'b0;
  logic            wbuf_wait = 1'b0;
  logic            busy;
  logic            done;
  logic            err;

  int total = 0;
  int bad = 0;
  int ts_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  acc_tile_sched #(
    .TX_W(8),
    .TY_W(8),
    .OC_W(6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_tiles_x(cfg_tiles_x),
    .cfg_tiles_y(cfg_tiles_y),
    .cfg_oc_grps(cfg_oc_grps),
    .tile_start (tile_start),
    .tile_x     (tile_x),
    .tile_y     (tile_y),
    .tile_oc    (tile_oc),
    .tile_last  (tile_last),
    .tile_done  (tile_done),
    .wbuf_wait  (wbuf_wait),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tile_start === 1'b1) ts_cnt++;
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  typedef struct {
    int x;
    int y;
    int oc;
    int last;
  } tile_exp_t;

  tile_exp_t t1_exp[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tile(input string nm, input int x, input int y, input int oc, input int last);
    chk({nm, "_start"}, int'(tile_start), 1);
    chk({nm, "_x"}, int'(tile_x), x);
    chk({nm, "_y"}, int'(tile_y), y);
    chk({nm, "_oc"}, int'(tile_oc), oc);
    chk({nm, "_last"}, int'(tile_last), last);
  endtask

  task automatic launch(input int tx, input int ty, input int ocg);
    cfg_tiles_x = 8'(tx);
    cfg_tiles_y = 8'(ty);
    cfg_oc_grps = 6'(ocg);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ts0, dn0, bz0;
    t1_exp[0] = '{x: 0, y: 0, oc: 0, last: 0};
    t1_exp[1] = '{x: 1, y: 0, oc: 0, last: 0};
    t1_exp[2] = '{x: 0, y: 1, oc: 0, last: 0};
    t1_exp[3] = '{x: 1, y: 1, oc: 0, last: 1};

    // Reset state
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_start", int'(tile_start), 0);
    chk("rst_last", int'(tile_last), 0);
    chk("rst_x", int'(tile_x), 0);
    tick();
    rst = 1'b0;
    tick();

    // Job (2,2,1), tile_done 3 cycles after each tile_start
    ts0 = ts_cnt; dn0 = done_cnt;
    launch(2, 2, 1);
    chk("t1_busy", int'(busy), 1);
    cfg_tiles_x = 8'd7;  // must not disturb the running job
    for (int i = 0; i < 4; i++) begin
      chk_tile($sformatf("t1_tile%0d", i), t1_exp[i].x, t1_exp[i].y, t1_exp[i].oc,
               t1_exp[i].last);
      tick();
      chk("t1_pulse_once", int'(tile_start), 0);
      tick();
      tick();
      tile_done = 1'b1;
      tick();
      tile_done = 1'b0;
      if (i == 3) begin
        chk("t1_done", int'(done), 1);
        chk("t1_busy_at_done", int'(busy), 0);
      end else begin
        chk("t1_done_early", int'(done), 0);
      end
    end
    tick();
    chk("t1_done_one_cycle", int'(done), 0);
    tick();
    chk("t1_starts", ts_cnt - ts0, 4);
    chk("t1_dones", done_cnt - dn0, 1);

    // Job (1,1,2) with write-buffer backpressure after the first tile
    ts0 = ts_cnt; dn0 = done_cnt;
    launch(1, 1, 2);
    chk_tile("t2_tile0", 0, 0, 0, 0);
    tick();
    tile_done = 1'b1;
    wbuf_wait = 1'b1;
    tick();
    tile_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_nostart", int'(tile_start), 0);
      chk("t2_hold_busy", int'(busy), 1);
      tick();
    end
    wbuf_wait = 1'b0;
    tick();
    chk_tile("t2_tile1", 0, 0, 1, 1);
    tick();
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    chk("t2_done", int'(done), 1);
    tick();
    tick();
    chk("t2_dones", done_cnt - dn0, 1);
    chk("t2_starts", ts_cnt - ts0, 2);
    chk("t2_err", int'(err), 0);

    // Zero Y count: immediate done, no tiles, never busy
    ts0 = ts_cnt; dn0 = done_cnt; bz0 = busy_cnt;
    launch(2, 0, 1);
    chk("t3_done", int'(done), 1);
    chk("t3_busy", int'(busy), 0);
    tick();
    chk("t3_done_one_cycle", int'(done), 0);
    tick();
    chk("t3_starts", ts_cnt - ts0, 0);
    chk("t3_busy_cycles", busy_cnt - bz0, 0);
    chk("t3_dones", done_cnt - dn0, 1);

    // Abort coinciding with tile_done in RUN of tile 1
    ts0 = ts_cnt; dn0 = done_cnt;
    launch(3, 1, 1);
    chk_tile("t4_tile0", 0, 0, 0, 0);
    tick();
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    chk_tile("t4_tile1", 1, 0, 0, 0);
    tick();
    abort = 1'b1;
    tile_done = 1'b1;
    tick();
    abort = 1'b0;
    tile_done = 1'b0;
    chk("t4_busy", int'(busy), 0);
    chk("t4_done", int'(done), 0);
    chk("t4_err", int'(err), 0);
    chk("t4_x_kept", int'(tile_x), 1);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_starts", ts_cnt - ts0, 2);
    chk("t4_dones", done_cnt - dn0, 0);

    // Spurious tile_done in IDLE sets a sticky err; next start clears it
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    chk("t5_err_set", int'(err), 1);
    tick();
    tick();
    chk("t5_err_held", int'(err), 1);
    dn0 = done_cnt;
    launch(1, 1, 1);
    chk("t5_err_clr", int'(err), 0);
    chk_tile("t5_tile0", 0, 0, 0, 1);
    tick();
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    chk("t5_done", int'(done), 1);
    tick();
    tick();
    chk("t5_dones", done_cnt - dn0, 1);

    // Asynchronous reset mid-RUN
    dn0 = done_cnt;
    launch(2, 1, 1);
    tick();
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    tick();
    chk("t6_busy_before", int'(busy), 1);
    chk("t6_x_before", int'(tile_x), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_x", int'(tile_x), 0);
    chk("t6_last", int'(tile_last), 0);
    chk("t6_start", int'(tile_start), 0);
    chk("t6_done", int'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_no_done", done_cnt - dn0, 0);
    launch(1, 1, 1);
    chk_tile("t6_fresh", 0, 0, 0, 1);
    tick();
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    chk("t6_fresh_done", int'(done), 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
